// File: rtl/ram_arbiter_pkg.sv
// Shared definitions for the two-master RAM arbiter: FSM encoding and
// default geometry of the RAM controller port.
package ram_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  localparam int DEFAULT_ADDR_W  = 17;
  localparam int DEFAULT_DATA_W  = 16;
  localparam int DEFAULT_TIMEOUT = 15;

  // Address bit that steers an access to RAM2 (1) or RAM1 (0).
  localparam int RAM_SEL_BIT = 16;

endpackage

// File: rtl/ram_arbiter_if.sv
// Bundle of both master request ports and the RAM controller port.
// slave is the arbiter's view; master is the view of whoever drives the requests and the RAM.
interface ram_arbiter_if
  import ram_arbiter_pkg::*;
#(
  parameter int ADDR_W = DEFAULT_ADDR_W,
  parameter int DATA_W = DEFAULT_DATA_W
);

  logic              m0_req;
  logic              m0_we;
  logic [ADDR_W-1:0] m0_addr;
  logic [DATA_W-1:0] m0_wdata;
  logic              m0_gnt;
  logic              m0_done;
  logic [DATA_W-1:0] m0_rdata;

  logic              m1_req;
  logic              m1_we;
  logic [ADDR_W-1:0] m1_addr;
  logic [DATA_W-1:0] m1_wdata;
  logic              m1_gnt;
  logic              m1_done;
  logic [DATA_W-1:0] m1_rdata;

  logic              m_err;

  logic              ram_en;
  logic              ram_re;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_data_in;
  logic [DATA_W-1:0] ram_data_out;
  logic              ram_done;

  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata,
    input  m1_req, m1_we, m1_addr, m1_wdata,
    input  ram_data_out, ram_done,
    output m0_gnt, m0_done, m0_rdata,
    output m1_gnt, m1_done, m1_rdata,
    output m_err,
    output ram_en, ram_re, ram_we, ram_addr, ram_data_in
  );

  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata,
    output m1_req, m1_we, m1_addr, m1_wdata,
    output ram_data_out, ram_done,
    input  m0_gnt, m0_done, m0_rdata,
    input  m1_gnt, m1_done, m1_rdata,
    input  m_err,
    input  ram_en, ram_re, ram_we, ram_addr, ram_data_in
  );

endinterface

// File: rtl/ram_arbiter_rr_arbiter2.sv
// Combinational two-way round-robin pick: on a tie the master that was not
// served last wins, otherwise the only requester wins.
module rr_arbiter2
  import ram_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_served,
  output logic       valid,
  output logic       winner
);

  always_comb begin
    valid  = |req;
    winner = 1'b0;
    if (req == 2'b11) begin
      winner = ~last_served;
    end else begin
      winner = req[1];
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Two-master arbiter in front of a single RAM controller. One access at a time,
// walked through IDLE -> ISSUE -> WAIT -> RESP, with a timeout on the RAM handshake.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int ADDR_W  = DEFAULT_ADDR_W,
  parameter int DATA_W  = DEFAULT_DATA_W,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input logic          clk,
  input logic          rst,
  ram_arbiter_if.slave bus
);

  localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  // The WAIT cycle in which the counter would reach TIMEOUT is the last one allowed.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT < 1) ? 0 : TIMEOUT - 1);

  state_t            state;
  logic              owner;
  logic              last_served;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [CNT_W-1:0]  timer;
  logic              err_q;
  logic [1:0]        gnt_q;
  logic [1:0]        done_q;
  logic              ram_en_q;
  logic              ram_re_q;
  logic              ram_we_q;
  logic [DATA_W-1:0] rdata0_q;
  logic [DATA_W-1:0] rdata1_q;

  logic [1:0]        req;
  logic              pick_valid;
  logic              pick;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  assign req       = {bus.m1_req, bus.m0_req};
  assign sel_we    = pick ? bus.m1_we    : bus.m0_we;
  assign sel_addr  = pick ? bus.m1_addr  : bus.m0_addr;
  assign sel_wdata = pick ? bus.m1_wdata : bus.m0_wdata;

  rr_arbiter2 u_rr (
    .req         (req),
    .last_served (last_served),
    .valid       (pick_valid),
    .winner      (pick)
  );

  // Single FSM; every output is a register updated alongside the state transition.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_IDLE;
      owner       <= 1'b0;
      last_served <= 1'b1;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      timer       <= '0;
      err_q       <= 1'b0;
      gnt_q       <= 2'b00;
      done_q      <= 2'b00;
      ram_en_q    <= 1'b0;
      ram_re_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pick_valid) begin
            owner    <= pick;
            we_q     <= sel_we;
            addr_q   <= sel_addr;
            wdata_q  <= sel_wdata;
            gnt_q    <= pick ? 2'b10 : 2'b01;
            ram_en_q <= 1'b1;
            ram_re_q <= ~sel_we;
            ram_we_q <= sel_we;
            state    <= ST_ISSUE;
          end
        end

        ST_ISSUE: begin
          ram_re_q <= 1'b0;
          ram_we_q <= 1'b0;
          timer    <= '0;
          state    <= ST_WAIT;
        end

        // A RAM completion wins over a timeout landing in the same cycle.
        ST_WAIT: begin
          if (bus.ram_done) begin
            if (!we_q) begin
              if (owner) begin
                rdata1_q <= bus.ram_data_out;
              end else begin
                rdata0_q <= bus.ram_data_out;
              end
            end
            err_q    <= 1'b0;
            done_q   <= gnt_q;
            ram_en_q <= 1'b0;
            state    <= ST_RESP;
          end else if (timer == CNT_LAST) begin
            err_q    <= 1'b1;
            done_q   <= gnt_q;
            ram_en_q <= 1'b0;
            timer    <= timer + CNT_W'(1);
            state    <= ST_RESP;
          end else begin
            timer <= timer + CNT_W'(1);
          end
        end

        ST_RESP: begin
          gnt_q       <= 2'b00;
          done_q      <= 2'b00;
          err_q       <= 1'b0;
          last_served <= owner;
          state       <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.m0_gnt      = gnt_q[0];
  assign bus.m1_gnt      = gnt_q[1];
  assign bus.m0_done     = done_q[0];
  assign bus.m1_done     = done_q[1];
  assign bus.m0_rdata    = rdata0_q;
  assign bus.m1_rdata    = rdata1_q;
  assign bus.m_err       = err_q;
  assign bus.ram_en      = ram_en_q;
  assign bus.ram_re      = ram_re_q;
  assign bus.ram_we      = ram_we_q;
  assign bus.ram_addr    = addr_q;
  assign bus.ram_data_in = wdata_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: a small RAM model answers each issued access
// after a programmable number of WAIT cycles (0 = never, forcing a timeout).
module tb_ram_arbiter;
  import ram_arbiter_pkg::*;

  localparam int ADDR_W  = 17;
  localparam int DATA_W  = 16;
  localparam int TIMEOUT = 15;

  logic clk = 1'b0;
  logic rst = 1'b0;

  int tests_run    = 0;
  int tests_failed = 0;

  int                ram_latency   = 1;
  int                wait_cnt      = 0;
  logic [DATA_W-1:0] ram_rdata_val = '0;

  ram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  ram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  // RAM model: ram_done rises in WAIT cycle number ram_latency after the strobe.
  initial begin
    bus.ram_done     = 1'b0;
    bus.ram_data_out = '0;
    forever begin
      @(posedge clk);
      #2;
      bus.ram_done     = 1'b0;
      bus.ram_data_out = ram_rdata_val;
      if (bus.ram_re || bus.ram_we) begin
        wait_cnt = ram_latency;
      end else if (wait_cnt > 0) begin
        wait_cnt--;
        if (wait_cnt == 0) bus.ram_done = 1'b1;
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_req(input logic m, input logic we, input logic [ADDR_W-1:0] addr,
                           input logic [DATA_W-1:0] wdata);
    if (m) begin
      bus.m1_req = 1'b1; bus.m1_we = we; bus.m1_addr = addr; bus.m1_wdata = wdata;
    end else begin
      bus.m0_req = 1'b1; bus.m0_we = we; bus.m0_addr = addr; bus.m0_wdata = wdata;
    end
  endtask

  task automatic drop_req();
    bus.m0_req = 1'b0;
    bus.m1_req = 1'b0;
  endtask

  function automatic logic [7:0] ctl_bits();
    return {bus.m0_gnt, bus.m1_gnt, bus.m0_done, bus.m1_done, bus.m_err,
            bus.ram_en, bus.ram_re, bus.ram_we};
  endfunction

  task automatic test_reset();
    #12;
    tests_run++;
    if (ctl_bits() !== 8'h00) begin
      tests_failed++; $display("[TB] FAIL reset_ctl: got %b want 00000000", ctl_bits());
    end
    tests_run++;
    if (bus.ram_addr !== 17'h0) begin
      tests_failed++; $display("[TB] FAIL reset_addr: got %h want 0", bus.ram_addr);
    end
    tests_run++;
    if (bus.ram_data_in !== 16'h0) begin
      tests_failed++; $display("[TB] FAIL reset_wdata: got %h want 0", bus.ram_data_in);
    end
    tests_run++;
    if ({bus.m0_rdata, bus.m1_rdata} !== 32'h0) begin
      tests_failed++; $display("[TB] FAIL reset_rdata: got %h/%h want 0/0", bus.m0_rdata, bus.m1_rdata);
    end
    rst = 1'b1;
    tick();
    tests_run++;
    if (ctl_bits() !== 8'h00) begin
      tests_failed++; $display("[TB] FAIL idle_ctl: got %b want 00000000", ctl_bits());
    end
  endtask

  task automatic test_write();
    ram_latency = 1;
    start_req(1'b0, 1'b1, 17'h00005, 16'h1234);
    tick();
    tests_run++;
    if ({bus.m1_gnt, bus.m0_gnt, bus.ram_en, bus.ram_re, bus.ram_we} !== 5'b01101) begin
      tests_failed++;
      $display("[TB] FAIL wr_issue: got gnt=%b%b en=%b re=%b we=%b want 01 1 0 1",
               bus.m1_gnt, bus.m0_gnt, bus.ram_en, bus.ram_re, bus.ram_we);
    end
    tests_run++;
    if (bus.ram_addr !== 17'h00005 || bus.ram_data_in !== 16'h1234) begin
      tests_failed++; $display("[TB] FAIL wr_bus: got %h/%h want 00005/1234", bus.ram_addr, bus.ram_data_in);
    end
    tick();
    tests_run++;
    if ({bus.m0_gnt, bus.ram_en, bus.ram_re, bus.ram_we, bus.m0_done} !== 5'b11000) begin
      tests_failed++;
      $display("[TB] FAIL wr_wait: got gnt=%b en=%b re=%b we=%b done=%b want 1 1 0 0 0",
               bus.m0_gnt, bus.ram_en, bus.ram_re, bus.ram_we, bus.m0_done);
    end
    tick();
    tests_run++;
    if ({bus.m0_done, bus.m1_done, bus.m_err} !== 3'b100 || bus.ram_addr !== 17'h00005) begin
      tests_failed++;
      $display("[TB] FAIL wr_done: got done=%b%b err=%b addr=%h want 10 0 00005",
               bus.m0_done, bus.m1_done, bus.m_err, bus.ram_addr);
    end
    drop_req();
    tick();
    tests_run++;
    if (ctl_bits() !== 8'h00) begin
      tests_failed++; $display("[TB] FAIL wr_idle: got %b want 00000000", ctl_bits());
    end
  endtask

  task automatic test_read();
    logic [ADDR_W-1:0] ram2_addr;
    ram2_addr = (ADDR_W'(1) << RAM_SEL_BIT) | ADDR_W'(5);
    ram_latency   = 1;
    ram_rdata_val = 16'hA5A5;
    start_req(1'b0, 1'b0, 17'h00007, 16'h0000);
    tick();
    tests_run++;
    if ({bus.ram_re, bus.ram_we} !== 2'b10) begin
      tests_failed++; $display("[TB] FAIL rd0_strobe: got re=%b we=%b want 1 0", bus.ram_re, bus.ram_we);
    end
    tick();
    tick();
    tests_run++;
    if (bus.m0_done !== 1'b1 || bus.m0_rdata !== 16'hA5A5) begin
      tests_failed++; $display("[TB] FAIL rd0_data: got done=%b rdata=%h want 1 a5a5", bus.m0_done, bus.m0_rdata);
    end
    drop_req();
    tick();

    ram_rdata_val = 16'h1233;
    start_req(1'b1, 1'b0, ram2_addr, 16'h0000);
    tick();
    tests_run++;
    if ({bus.m1_gnt, bus.m0_gnt, bus.ram_re, bus.ram_we} !== 4'b1010 || bus.ram_addr !== 17'h10005) begin
      tests_failed++;
      $display("[TB] FAIL rd1_issue: got gnt=%b%b re=%b we=%b addr=%h want 10 1 0 10005",
               bus.m1_gnt, bus.m0_gnt, bus.ram_re, bus.ram_we, bus.ram_addr);
    end
    tick();
    tests_run++;
    if (bus.ram_re !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL rd1_re_pulse: got re=%b want 0", bus.ram_re);
    end
    tick();
    tests_run++;
    if ({bus.m1_done, bus.m0_done, bus.m_err} !== 3'b100 || bus.m1_rdata !== 16'h1233) begin
      tests_failed++;
      $display("[TB] FAIL rd1_done: got done=%b%b err=%b rdata=%h want 10 0 1233",
               bus.m1_done, bus.m0_done, bus.m_err, bus.m1_rdata);
    end
    tests_run++;
    if (bus.m0_rdata !== 16'hA5A5) begin
      tests_failed++; $display("[TB] FAIL rd1_m0_keep: got %h want a5a5", bus.m0_rdata);
    end
    drop_req();
    tick();
  endtask

  task automatic test_back_to_back();
    int overlap = 0;
    int n = 0;
    int order[4];
    int dtick[4];
    ram_latency = 1;
    start_req(1'b0, 1'b1, 17'h00010, 16'h0A0A);
    start_req(1'b1, 1'b1, 17'h10010, 16'h0B0B);
    for (int cyc = 1; cyc <= 16; cyc++) begin
      tick();
      if (bus.m0_gnt && bus.m1_gnt) overlap++;
      if (bus.m0_done || bus.m1_done) begin
        if (n < 4) begin
          order[n] = bus.m1_done ? 1 : 0;
          dtick[n] = cyc;
        end
        n++;
      end
    end
    drop_req();
    tests_run++;
    if (overlap !== 0) begin
      tests_failed++; $display("[TB] FAIL rr_overlap: got %0d cycles with both gnt want 0", overlap);
    end
    tests_run++;
    if (n !== 4) begin
      tests_failed++; $display("[TB] FAIL rr_count: got %0d done pulses want 4", n);
    end
    for (int i = 0; i < 4; i++) begin
      if (i < n) begin
        tests_run++;
        if (order[i] !== (i % 2)) begin
          tests_failed++; $display("[TB] FAIL rr_order[%0d]: got m%0d want m%0d", i, order[i], i % 2);
        end
        tests_run++;
        if (dtick[i] !== 3 + 4 * i) begin
          tests_failed++; $display("[TB] FAIL rr_timing[%0d]: got cycle %0d want %0d", i, dtick[i], 3 + 4 * i);
        end
      end
    end
    tick();
  endtask

  task automatic test_timeout();
    int done_tick = -1;
    int stray_err = 0;
    logic err_at_done = 1'b0;
    ram_latency   = 0;
    ram_rdata_val = 16'hDEAD;
    start_req(1'b0, 1'b0, 17'h00009, 16'h0000);
    for (int cyc = 1; cyc <= 40 && done_tick < 0; cyc++) begin
      tick();
      if (bus.m0_done) begin
        done_tick   = cyc;
        err_at_done = bus.m_err;
      end else if (bus.m_err) begin
        stray_err++;
      end
    end
    tests_run++;
    if (done_tick !== TIMEOUT + 2) begin
      tests_failed++; $display("[TB] FAIL to_latency: got done at cycle %0d want %0d", done_tick, TIMEOUT + 2);
    end
    tests_run++;
    if (err_at_done !== 1'b1 || stray_err !== 0) begin
      tests_failed++; $display("[TB] FAIL to_err: got err=%b stray=%0d want 1 0", err_at_done, stray_err);
    end
    tests_run++;
    if (bus.m0_rdata !== 16'hA5A5) begin
      tests_failed++; $display("[TB] FAIL to_rdata_keep: got %h want a5a5", bus.m0_rdata);
    end
    drop_req();
    tick();
    tests_run++;
    if (bus.m_err !== 1'b0 || bus.m0_done !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL to_pulse: got err=%b done=%b want 0 0", bus.m_err, bus.m0_done);
    end
  endtask

  task automatic test_reset_mid_access();
    int stray_done = 0;
    ram_latency = 0;
    start_req(1'b1, 1'b1, 17'h10003, 16'h5555);
    tick();
    tick();
    tick();
    #2;
    rst = 1'b0;
    #1;
    tests_run++;
    if (ctl_bits() !== 8'h00) begin
      tests_failed++; $display("[TB] FAIL mid_rst_ctl: got %b want 00000000", ctl_bits());
    end
    tests_run++;
    if (bus.ram_addr !== 17'h0 || bus.ram_data_in !== 16'h0) begin
      tests_failed++; $display("[TB] FAIL mid_rst_bus: got %h/%h want 0/0", bus.ram_addr, bus.ram_data_in);
    end
    tests_run++;
    if (bus.m0_rdata !== 16'h0 || bus.m1_rdata !== 16'h0) begin
      tests_failed++; $display("[TB] FAIL mid_rst_rdata: got %h/%h want 0/0", bus.m0_rdata, bus.m1_rdata);
    end
    drop_req();
    for (int cyc = 0; cyc < 3; cyc++) begin
      tick();
      if (bus.m0_done || bus.m1_done) stray_done++;
    end
    #2;
    rst = 1'b1;
    tick();
    if (bus.m0_done || bus.m1_done) stray_done++;
    tests_run++;
    if (stray_done !== 0) begin
      tests_failed++; $display("[TB] FAIL mid_rst_nodone: got %0d done pulses want 0", stray_done);
    end

    ram_latency   = 1;
    ram_rdata_val = 16'h4321;
    start_req(1'b1, 1'b0, 17'h00011, 16'h0000);
    tick();
    tests_run++;
    if ({bus.m1_gnt, bus.m0_gnt, bus.ram_re} !== 3'b101) begin
      tests_failed++; $display("[TB] FAIL post_rst_issue: got gnt=%b%b re=%b want 10 1", bus.m1_gnt, bus.m0_gnt, bus.ram_re);
    end
    tick();
    tick();
    tests_run++;
    if (bus.m1_done !== 1'b1 || bus.m_err !== 1'b0 || bus.m1_rdata !== 16'h4321) begin
      tests_failed++;
      $display("[TB] FAIL post_rst_done: got done=%b err=%b rdata=%h want 1 0 4321", bus.m1_done, bus.m_err, bus.m1_rdata);
    end
    drop_req();
    tick();
  endtask

  initial begin
    bus.m0_req = 1'b0; bus.m0_we = 1'b0; bus.m0_addr = '0; bus.m0_wdata = '0;
    bus.m1_req = 1'b0; bus.m1_we = 1'b0; bus.m1_addr = '0; bus.m1_wdata = '0;
    test_reset();
    test_write();
    test_read();
    test_back_to_back();
    test_timeout();
    test_reset_mid_access();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
